// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASSA = 4'h0,
    OP_PASSB = 4'h1,
    OP_NOTA  = 4'h2,
    OP_ADD   = 4'h3,
    OP_ADC   = 4'h4,
    OP_SUB   = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_NAND  = 4'h9,
    OP_LSL   = 4'hA,
    OP_LSR   = 4'hB,
    OP_ASR   = 4'hC,
    OP_CSL   = 4'hD,
    OP_MUL   = 4'hE,
    OP_DIV   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2
  } state_e;

  // Which algorithm the iterative core runs.
  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  // Bit positions inside the {Z, C, N, O} flag word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  // MUL always iterates; DIV iterates unless the divisor is zero.
  function automatic logic is_iterative(input logic [3:0] op, input logic divisor_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply (shift-add, LSB first) and restoring divide
// (MSB first), one bit per step. Results sit in o_hi/o_lo once o_last rises.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  md_mode_e         i_mode,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  md_mode_e         r_mode;
  logic [WIDTH-1:0] r_hi;    // MUL: product high half / DIV: partial remainder
  logic [WIDTH-1:0] r_lo;    // MUL: multiplier -> product low half / DIV: dividend -> quotient
  logic [WIDTH-1:0] r_opnd;  // MUL: multiplicand / DIV: divisor
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;

  // Multiply: add the multiplicand when the current multiplier bit is set,
  // then shift the whole {hi, lo} pair right by one.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Divide: bring the next dividend bit into the remainder and trial-subtract.
  // The remainder is always below the divisor, so WIDTH+1 bits never overflow
  // and the top bit of the trial result is the "negative" indicator.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = ~w_div_trial[WIDTH];

  assign o_last = (r_cnt == CNT_W'(WIDTH));
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;

  // Load operands on i_load, otherwise advance one bit per i_step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode <= MD_MUL;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_hi   <= '0;
      r_lo   <= (i_mode == MD_DIV) ? i_a : i_b;
      r_opnd <= (i_mode == MD_DIV) ? i_b : i_a;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_mode == MD_DIV) begin
        r_hi <= w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
      end else begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV
// behind a Start/Busy/Done handshake with a registered {Z,C,N,O} flag word.
// A new Start is taken whenever Busy is low, which includes the EXEC cycle and
// the final result cycle of an iteration, so EXEC ops can issue every cycle.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_fun_sel,
  input  logic             i_wf,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_alu_out,
  output logic [WIDTH-1:0] o_alu_out_hi,
  output logic [3:0]       o_flags_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam int MSB = WIDTH - 1;

  state_e           r_state;
  opcode_e          r_op;
  logic             r_wf;
  logic             r_cin;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] r_alu_out_hi;
  logic [3:0]       r_flags;
  logic             r_done;

  logic             w_busy;
  logic             w_accept;
  logic             w_start_iter;
  logic             w_finish;
  logic             w_core_last;
  logic [WIDTH-1:0] w_core_lo;
  logic [WIDTH-1:0] w_core_hi;
  logic             w_cin;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_res_c;
  logic             w_res_o;
  logic [3:0]       w_res_flags;

  // Busy covers the WIDTH step cycles; the result cycle after them is not busy.
  assign w_busy       = (r_state == ST_ITER) && !w_core_last;
  assign w_accept     = i_start && !w_busy;
  assign w_start_iter = is_iterative(i_fun_sel, (i_b == '0));
  assign w_finish     = (r_state == ST_EXEC) || ((r_state == ST_ITER) && w_core_last);
  assign w_cin        = (r_op == OP_ADC) && r_cin;

  seq_muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_mode  ((i_fun_sel == OP_DIV) ? MD_DIV : MD_MUL),
    .i_load  (w_accept && w_start_iter),
    .i_step  (w_busy),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_last  (w_core_last),
    .o_lo    (w_core_lo),
    .o_hi    (w_core_hi)
  );

  // Result datapath: the single-cycle ops (incl. divide by zero) or the core.
  always_comb begin
    w_res_lo = '0;
    w_res_hi = '0;
    w_res_c  = 1'b0;
    w_res_o  = 1'b0;
    w_ext    = '0;
    if (r_state == ST_ITER) begin
      w_res_lo = w_core_lo;
      w_res_hi = w_core_hi;
    end else begin
      case (r_op)
        OP_PASSA: w_res_lo = r_a;
        OP_PASSB: w_res_lo = r_b;
        OP_NOTA:  w_res_lo = ~r_a;
        OP_ADD, OP_ADC: begin
          w_ext    = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_cin};
          w_res_lo = w_ext[MSB:0];
          w_res_c  = w_ext[WIDTH];
          w_res_o  = (r_a[MSB] == r_b[MSB]) && (w_ext[MSB] != r_a[MSB]);
        end
        OP_SUB: begin
          w_ext    = {1'b0, r_a} - {1'b0, r_b};
          w_res_lo = w_ext[MSB:0];
          w_res_c  = w_ext[WIDTH];
          w_res_o  = (r_a[MSB] != r_b[MSB]) && (w_ext[MSB] != r_a[MSB]);
        end
        OP_AND:  w_res_lo = r_a & r_b;
        OP_OR:   w_res_lo = r_a | r_b;
        OP_XOR:  w_res_lo = r_a ^ r_b;
        OP_NAND: w_res_lo = ~(r_a & r_b);
        OP_LSL: begin
          w_res_lo = {r_a[MSB-1:0], 1'b0};
          w_res_c  = r_a[MSB];
        end
        OP_LSR: begin
          w_res_lo = {1'b0, r_a[MSB:1]};
          w_res_c  = r_a[0];
        end
        OP_ASR: begin
          w_res_lo = {r_a[MSB], r_a[MSB:1]};
          w_res_c  = r_a[0];
        end
        OP_CSL: begin
          w_res_lo = {r_a[MSB-1:0], r_a[MSB]};
          w_res_c  = r_a[MSB];
        end
        OP_MUL: begin
          // MUL never reaches EXEC
        end
        OP_DIV: begin
          // Divide by zero: all-ones quotient, dividend as remainder
          w_res_lo = '1;
          w_res_hi = r_a;
          w_res_c  = 1'b1;
        end
      endcase
    end
  end

  // Flag word for the completing op; MUL and DIV define Z/N/C differently.
  always_comb begin
    w_res_flags = '0;
    if (r_op == OP_MUL) begin
      w_res_flags[FLAG_Z] = (w_res_hi == '0) && (w_res_lo == '0);
      w_res_flags[FLAG_C] = (w_res_hi != '0);
      w_res_flags[FLAG_N] = w_res_hi[MSB];
    end else if (r_op == OP_DIV) begin
      w_res_flags[FLAG_Z] = (w_res_lo == '0);
      w_res_flags[FLAG_C] = w_res_c;
    end else begin
      w_res_flags[FLAG_Z] = (w_res_lo == '0);
      w_res_flags[FLAG_C] = w_res_c;
      w_res_flags[FLAG_N] = w_res_lo[MSB];
      w_res_flags[FLAG_O] = w_res_o;
    end
  end

  // FSM and operand capture; a Start in the completing cycle chains directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_PASSA;
      r_wf    <= 1'b0;
      r_cin   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (w_accept) begin
      r_op    <= opcode_e'(i_fun_sel);
      r_wf    <= i_wf;
      r_cin   <= r_flags[FLAG_C];
      r_a     <= i_a;
      r_b     <= i_b;
      r_state <= w_start_iter ? ST_ITER : ST_EXEC;
    end else if (w_finish) begin
      r_state <= ST_IDLE;
    end
  end

  // Output and flag registers update only in the Done cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alu_out    <= '0;
      r_alu_out_hi <= '0;
      r_flags      <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_alu_out    <= w_res_lo;
        r_alu_out_hi <= w_res_hi;
        if (r_wf) begin
          r_flags <= w_res_flags;
        end
      end
    end
  end

  assign o_alu_out    = r_alu_out;
  assign o_alu_out_hi = r_alu_out_hi;
  assign o_flags_out  = r_flags;
  assign o_busy       = w_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed bench for seq_alu_unit: a WIDTH=32 and a WIDTH=16 instance.
module tb_seq_alu_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32 = 1'b1, start32 = 1'b0, wf32 = 1'b0;
  logic [3:0]  fun32 = '0;
  logic [31:0] a32 = '0, b32 = '0, out32, hi32;
  logic [3:0]  flags32;
  logic        busy32, done32;

  logic        rst16 = 1'b1, start16 = 1'b0, wf16 = 1'b0;
  logic [3:0]  fun16 = '0;
  logic [15:0] a16 = '0, b16 = '0, out16, hi16;
  logic [3:0]  flags16;
  logic        busy16, done16;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu_unit #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_reset(rst32), .i_start(start32), .i_fun_sel(fun32), .i_wf(wf32),
    .i_a(a32), .i_b(b32), .o_alu_out(out32), .o_alu_out_hi(hi32),
    .o_flags_out(flags32), .o_busy(busy32), .o_done(done32)
  );

  seq_alu_unit #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_reset(rst16), .i_start(start16), .i_fun_sel(fun16), .i_wf(wf16),
    .i_a(a16), .i_b(b16), .o_alu_out(out16), .o_alu_out_hi(hi16),
    .o_flags_out(flags16), .o_busy(busy16), .o_done(done16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic w);
    fun32 = f; a32 = a; b32 = b; wf32 = w; start32 = 1'b1;
  endtask

  task automatic go16(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input logic w);
    fun16 = f; a16 = a; b16 = b; wf16 = w; start16 = 1'b1;
  endtask

  // Runs an already-accepted iterative op on the 32-bit DUT for 40 cycles.
  task automatic run_iter32(output int done_at, output int n_busy, output int n_done,
                            output logic [31:0] lo, output logic [31:0] hi,
                            output logic [3:0] fl, output logic [31:0] mid_out);
    done_at = -1; n_busy = busy32 ? 1 : 0; n_done = 0; lo = '0; hi = '0; fl = '0; mid_out = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy32) n_busy++;
      if (k == 16) mid_out = out32;
      if (done32) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k; lo = out32; hi = hi32; fl = flags32;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst32 = 1'b1; rst16 = 1'b1;
    tick(); tick();
    rst32 = 1'b0; rst16 = 1'b0;
    $display("reset: out=%h hi=%h flags=%b busy=%b done=%b", out32, hi32, flags32, busy32, done32);
    n_checks++; if (out32 !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want %h", out32, 32'h0); end
    n_checks++; if (hi32 !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", hi32, 32'h0); end
    n_checks++; if (flags32 !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags32); end
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy32); end
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done32); end
    n_checks++; if (flags16 !== 4'b0000) begin n_fail++; $display("FAIL reset16_flags: got %b want 0000", flags16); end
  endtask

  task automatic test_add_overflow();
    go32(4'h3, 32'h7FFFFFFF, 32'h1, 1'b1);
    tick(); start32 = 1'b0;
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL add_early_done: got %b want 0", done32); end
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL add_busy: got %b want 0", busy32); end
    tick();
    $display("add: out=%h flags=%b done=%b", out32, flags32, done32);
    n_checks++; if (done32 !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done32); end
    n_checks++; if (out32 !== 32'h80000000) begin n_fail++; $display("FAIL add_out: got %h want %h", out32, 32'h80000000); end
    n_checks++; if (flags32 !== 4'b0011) begin n_fail++; $display("FAIL add_flags: got %b want 0011", flags32); end
    tick();
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done32); end
  endtask

  task automatic test_back_to_back();
    // Set C=1 first: 0xFFFFFFFF + 1 = 0 with carry out
    go32(4'h3, 32'hFFFFFFFF, 32'h1, 1'b1);
    tick(); start32 = 1'b0; tick();
    $display("add_carry: out=%h flags=%b", out32, flags32);
    n_checks++; if (flags32 !== 4'b1100) begin n_fail++; $display("FAIL carry_flags: got %b want 1100", flags32); end
    // ADC (WF=0) then SUB issued in ADC's Done cycle
    go32(4'h4, 32'h1, 32'h1, 1'b0);
    tick();
    go32(4'h5, 32'h2, 32'h5, 1'b1);
    tick();
    $display("adc: out=%h flags=%b done=%b", out32, flags32, done32);
    n_checks++; if (done32 !== 1'b1) begin n_fail++; $display("FAIL adc_done: got %b want 1", done32); end
    n_checks++; if (out32 !== 32'h3) begin n_fail++; $display("FAIL adc_out: got %h want %h", out32, 32'h3); end
    n_checks++; if (flags32 !== 4'b1100) begin n_fail++; $display("FAIL adc_wf0_flags: got %b want 1100", flags32); end
    start32 = 1'b0;
    tick();
    $display("sub: out=%h flags=%b done=%b", out32, flags32, done32);
    n_checks++; if (done32 !== 1'b1) begin n_fail++; $display("FAIL sub_done: got %b want 1", done32); end
    n_checks++; if (out32 !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL sub_out: got %h want %h", out32, 32'hFFFFFFFD); end
    n_checks++; if (flags32 !== 4'b0110) begin n_fail++; $display("FAIL sub_flags: got %b want 0110", flags32); end
    tick();
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL sub_done_pulse: got %b want 0", done32); end
  endtask

  task automatic test_mul();
    int done_at, n_busy, n_done;
    logic [31:0] lo, hi, mid;
    logic [3:0] fl;
    go32(4'hE, 32'hFFFFFFFF, 32'h2, 1'b1);
    tick(); start32 = 1'b0;
    run_iter32(done_at, n_busy, n_done, lo, hi, fl, mid);
    $display("mul: done_at=%0d busy_cycles=%0d lo=%h hi=%h flags=%b", done_at, n_busy, lo, hi, fl);
    n_checks++; if (done_at !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", done_at); end
    n_checks++; if (n_busy !== 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", n_busy); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL mul_done_count: got %0d want 1", n_done); end
    n_checks++; if (mid !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL mul_out_hold: got %h want %h", mid, 32'hFFFFFFFD); end
    n_checks++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mul_lo: got %h want %h", lo, 32'hFFFFFFFE); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL mul_hi: got %h want %h", hi, 32'h1); end
    n_checks++; if (fl !== 4'b0100) begin n_fail++; $display("FAIL mul_flags: got %b want 0100", fl); end
  endtask

  task automatic test_div();
    int done_at, n_busy, n_done;
    logic [31:0] lo, hi, mid;
    logic [3:0] fl;
    go32(4'hF, 32'd100, 32'd7, 1'b1);
    tick(); start32 = 1'b0;
    run_iter32(done_at, n_busy, n_done, lo, hi, fl, mid);
    $display("div: done_at=%0d q=%h r=%h flags=%b", done_at, lo, hi, fl);
    n_checks++; if (done_at !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", done_at); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL div_quot: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %h want %h", hi, 32'd2); end
    n_checks++; if (fl !== 4'b0000) begin n_fail++; $display("FAIL div_flags: got %b want 0000", fl); end
    // Divide by zero completes through EXEC
    go32(4'hF, 32'd5, 32'd0, 1'b1);
    tick(); start32 = 1'b0;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL div0_busy: got %b want 0", busy32); end
    tick();
    $display("div0: done=%b q=%h r=%h flags=%b", done32, out32, hi32, flags32);
    n_checks++; if (done32 !== 1'b1) begin n_fail++; $display("FAIL div0_done: got %b want 1", done32); end
    n_checks++; if (out32 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_quot: got %h want %h", out32, 32'hFFFFFFFF); end
    n_checks++; if (hi32 !== 32'd5) begin n_fail++; $display("FAIL div0_rem: got %h want %h", hi32, 32'd5); end
    n_checks++; if (flags32 !== 4'b0100) begin n_fail++; $display("FAIL div0_flags: got %b want 0100", flags32); end
  endtask

  task automatic test_reset_mid_mul();
    int n_done = 0;
    go32(4'hE, 32'd3, 32'd5, 1'b1);
    tick(); start32 = 1'b0;
    repeat (9) tick();
    rst32 = 1'b1;
    tick();
    rst32 = 1'b0;
    $display("reset_mid_mul: out=%h hi=%h flags=%b busy=%b done=%b", out32, hi32, flags32, busy32, done32);
    n_checks++; if (out32 !== 32'h0) begin n_fail++; $display("FAIL rmid_out: got %h want %h", out32, 32'h0); end
    n_checks++; if (hi32 !== 32'h0) begin n_fail++; $display("FAIL rmid_hi: got %h want %h", hi32, 32'h0); end
    n_checks++; if (flags32 !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags: got %b want 0000", flags32); end
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy32); end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done32) n_done++;
    end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d dones want 0", n_done); end
    go32(4'h3, 32'd2, 32'd3, 1'b1);
    tick(); start32 = 1'b0; tick();
    $display("add_after_reset: out=%h done=%b", out32, done32);
    n_checks++; if (done32 !== 1'b1) begin n_fail++; $display("FAIL rmid_add_done: got %b want 1", done32); end
    n_checks++; if (out32 !== 32'd5) begin n_fail++; $display("FAIL rmid_add_out: got %h want %h", out32, 32'd5); end
  endtask

  task automatic test_ignored_start();
    int n_done = 0;
    int done_at = -1;
    logic [15:0] lo = '0, hi = '0;
    logic [3:0] fl = '0;
    go16(4'hE, 16'h8000, 16'h0004, 1'b1);
    tick(); start16 = 1'b0;
    repeat (4) tick();
    go16(4'h3, 16'h0001, 16'h0001, 1'b1);
    tick(); start16 = 1'b0;
    for (int k = 6; k <= 40; k++) begin
      tick();
      if (done16) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k; lo = out16; hi = hi16; fl = flags16;
        end
      end
    end
    $display("mul16_ignored_start: dones=%0d done_at=%0d lo=%h hi=%h flags=%b", n_done, done_at, lo, hi, fl);
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
    n_checks++; if (done_at !== 17) begin n_fail++; $display("FAIL ign_latency: got %0d want 17", done_at); end
    n_checks++; if (lo !== 16'h0000) begin n_fail++; $display("FAIL ign_lo: got %h want %h", lo, 16'h0000); end
    n_checks++; if (hi !== 16'h0002) begin n_fail++; $display("FAIL ign_hi: got %h want %h", hi, 16'h0002); end
    n_checks++; if (fl !== 4'b0100) begin n_fail++; $display("FAIL ign_flags: got %b want 0100", fl); end
  endtask

  task automatic test_wf_and_shifts();
    go16(4'hB, 16'h0000, 16'h0000, 1'b1);  // LSR 0 -> Z
    tick(); start16 = 1'b0; tick();
    $display("lsr16: out=%h flags=%b", out16, flags16);
    n_checks++; if (flags16 !== 4'b1000) begin n_fail++; $display("FAIL lsr_flags: got %b want 1000", flags16); end
    go16(4'h8, 16'h8000, 16'h0000, 1'b0);  // XOR, flags must hold
    tick(); start16 = 1'b0; tick();
    $display("xor16_wf0: out=%h flags=%b", out16, flags16);
    n_checks++; if (out16 !== 16'h8000) begin n_fail++; $display("FAIL xor_out: got %h want %h", out16, 16'h8000); end
    n_checks++; if (flags16 !== 4'b1000) begin n_fail++; $display("FAIL wf0_hold: got %b want 1000", flags16); end
    go16(4'hD, 16'h8001, 16'h0000, 1'b1);  // CSL
    tick(); start16 = 1'b0; tick();
    $display("csl16: out=%h flags=%b", out16, flags16);
    n_checks++; if (out16 !== 16'h0003) begin n_fail++; $display("FAIL csl_out: got %h want %h", out16, 16'h0003); end
    n_checks++; if (flags16 !== 4'b0100) begin n_fail++; $display("FAIL csl_flags: got %b want 0100", flags16); end
    go16(4'hC, 16'h8001, 16'h0000, 1'b1);  // ASR
    tick(); start16 = 1'b0; tick();
    $display("asr16: out=%h flags=%b", out16, flags16);
    n_checks++; if (out16 !== 16'hC000) begin n_fail++; $display("FAIL asr_out: got %h want %h", out16, 16'hC000); end
    n_checks++; if (flags16 !== 4'b0110) begin n_fail++; $display("FAIL asr_flags: got %b want 0110", flags16); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mul();
    test_div();
    test_reset_mid_mul();
    test_ignored_start();
    test_wf_and_shifts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
